// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, FSM state and op encodings for the load/store stage
package mem_access_stage_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int REG_W = 3;
  localparam int OFF_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_t;
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_STORE = 1'b1;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: request, data-memory and writeback signals of the load/store stage
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;
  logic in_valid, in_ready, in_op;
  logic [DATA_W-1:0] in_base, in_store_data;
  logic [OFF_W-1:0] in_offset;
  logic [REG_W-1:0] in_rd;
  logic mem_re, mem_we;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic wb_valid, wb_ready, wb_we, wb_fault;
  logic [REG_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [7:0] fault_count;
  modport slave (
    input in_valid, in_op, in_base, in_offset, in_store_data, in_rd, mem_rdata, wb_ready,
    output in_ready, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_fault, fault_count
  );
  modport master (
    output in_valid, in_op, in_base, in_offset, in_store_data, in_rd, mem_rdata, wb_ready,
    input in_ready, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
    input wb_valid, wb_we, wb_rd, wb_data, wb_fault, fault_count
  );
endinterface

// File: rtl/mem_access_stage_ea_calc.sv
// mem_access_stage_ea_calc: effective address base + sext(offset) and out-of-range flag
module mem_access_stage_ea_calc
  import mem_access_stage_pkg::*;
(
  input  logic [DATA_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] ea,
  output logic              fault
);
  always_comb begin
    ea = base + {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
    fault = |ea[DATA_W-1:ADDR_W];
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store FSM driving the data memory and returning writeback responses
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input logic clk,
  input logic reset,
  mem_access_stage_if.slave bus
);
  state_t state_q, state_d;
  logic op_q, op_d;
  logic in_ready_q, in_ready_d;
  logic mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, wb_fault_q, wb_fault_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [7:0] fault_count_q, fault_count_d;
  logic [DATA_W-1:0] ea;
  logic fault;
  mem_access_stage_ea_calc u_ea (.base(bus.in_base), .offset(bus.in_offset), .ea(ea), .fault(fault));
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    mem_raddr_d = mem_raddr_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d = wb_valid_q;
    wb_we_d = wb_we_q;
    wb_fault_d = wb_fault_q;
    wb_rd_d = wb_rd_q;
    wb_data_d = wb_data_q;
    fault_count_d = fault_count_q;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        op_d = bus.in_op;
        wb_rd_d = bus.in_rd;
        wb_fault_d = fault;
        if (fault) begin
          state_d = RESP;
          wb_valid_d = 1'b1;
          wb_we_d = 1'b0;
          wb_data_d = '0;
          fault_count_d = fault_count_q + {7'd0, ~&fault_count_q};
        end else begin
          state_d = ISSUE;
          mem_we_d = bus.in_op == OP_STORE;
          mem_re_d = bus.in_op == OP_LOAD;
          mem_waddr_d = bus.in_op == OP_STORE ? ea[ADDR_W-1:0] : mem_waddr_q;
          mem_wdata_d = bus.in_op == OP_STORE ? bus.in_store_data : mem_wdata_q;
          mem_raddr_d = bus.in_op == OP_LOAD ? ea[ADDR_W-1:0] : mem_raddr_q;
        end
      end
      ISSUE: begin
        state_d = op_q == OP_STORE ? RESP : CAPTURE;
        wb_valid_d = op_q == OP_STORE;
        wb_we_d = 1'b0;
        wb_data_d = '0;
      end
      CAPTURE: begin
        state_d = RESP;
        wb_valid_d = 1'b1;
        wb_we_d = 1'b1;
        wb_data_d = bus.mem_rdata;
      end
      RESP: if (bus.wb_ready) begin
        state_d = IDLE;
        wb_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= OP_LOAD;
      in_ready_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_fault_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      fault_count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      in_ready_q <= in_ready_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      mem_raddr_q <= mem_raddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q <= wb_we_d;
      wb_fault_q <= wb_fault_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      fault_count_q <= fault_count_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.mem_re = mem_re_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_we = wb_we_q;
  assign bus.wb_fault = wb_fault_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.fault_count = fault_count_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scenarios against a 64-word registered-read memory model
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0, re_cnt = 0, we_cnt = 0, both_cnt = 0;
  logic [DATA_W-1:0] mem [64];
  mem_access_stage_if bus();
  mem_access_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];
    re_cnt <= re_cnt + (bus.mem_re ? 1 : 0);
    we_cnt <= we_cnt + (bus.mem_we ? 1 : 0);
    both_cnt <= both_cnt + ((bus.mem_re && bus.mem_we) ? 1 : 0);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task req(input logic op, input logic [15:0] base, input logic [5:0] off, input logic [15:0] d, input logic [2:0] rd);
    bus.in_op = op;
    bus.in_base = base;
    bus.in_offset = off;
    bus.in_store_data = d;
    bus.in_rd = rd;
    bus.in_valid = 1'b1;
  endtask

  task test_reset;
    reset = 1'b0;
    bus.wb_ready = 1'b0;
    req(OP_LOAD, 16'h0, 6'h0, 16'h0, 3'd0);
    bus.in_valid = 1'b0;
    repeat (3) tick;
    total++;
    if ({bus.in_ready, bus.mem_re, bus.mem_we, bus.wb_valid, bus.wb_we, bus.wb_fault} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 000000", {bus.in_ready, bus.mem_re, bus.mem_we, bus.wb_valid, bus.wb_we, bus.wb_fault});
    end
    total++;
    if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.wb_rd, bus.wb_data, bus.fault_count} !== 55'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.wb_rd, bus.wb_data, bus.fault_count});
    end
    reset = 1'b1;
    tick;
    total++;
    if ({bus.in_ready, bus.wb_valid, bus.fault_count} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_release: got %h want 200", {bus.in_ready, bus.wb_valid, bus.fault_count});
    end
  endtask

  task test_store;
    int w0, r0;
    w0 = we_cnt;
    r0 = re_cnt;
    req(OP_STORE, 16'h0010, 6'd5, 16'hBEEF, 3'd2);
    tick;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.mem_we, bus.mem_re, bus.mem_waddr, bus.mem_wdata, bus.wb_valid, bus.in_ready} !== {1'b1, 1'b0, 6'd21, 16'hBEEF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL store_issue: got we=%b re=%b waddr=%0d wdata=%h wbv=%b rdy=%b want 1 0 21 beef 0 0", bus.mem_we, bus.mem_re, bus.mem_waddr, bus.mem_wdata, bus.wb_valid, bus.in_ready);
    end
    tick;
    total++;
    if ({bus.mem_we, bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL store_resp: got %h want %h", {bus.mem_we, bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_data}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
    end
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL store_done: got %b want 01", {bus.wb_valid, bus.in_ready});
    end
    total++;
    if (mem[21] !== 16'hBEEF) begin
      bad++;
      $display("FAIL store_mem: got %h want beef", mem[21]);
    end
    total++;
    if ({we_cnt - w0, re_cnt - r0} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL store_enables: got we=%0d re=%0d want 1 0", we_cnt - w0, re_cnt - r0);
    end
  endtask

  task test_load;
    req(OP_LOAD, 16'h0018, 6'h3D, 16'h0, 3'd4);
    tick;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.mem_re, bus.mem_we, bus.mem_raddr, bus.wb_valid} !== {1'b1, 1'b0, 6'd21, 1'b0}) begin
      bad++;
      $display("FAIL load_issue: got re=%b we=%b raddr=%0d wbv=%b want 1 0 21 0", bus.mem_re, bus.mem_we, bus.mem_raddr, bus.wb_valid);
    end
    tick;
    total++;
    if ({bus.mem_re, bus.wb_valid} !== 2'b00) begin
      bad++;
      $display("FAIL load_capture: got %b want 00", {bus.mem_re, bus.wb_valid});
    end
    tick;
    total++;
    if ({bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 1'b0, 3'd4, 16'hBEEF}) begin
      bad++;
      $display("FAIL load_resp: got v=%b we=%b f=%b rd=%0d data=%h want 1 1 0 4 beef", bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_rd, bus.wb_data);
    end
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL load_done: got %b want 01", {bus.wb_valid, bus.in_ready});
    end
  endtask

  task test_backpressure;
    int w0, r0;
    w0 = we_cnt;
    r0 = re_cnt;
    req(OP_LOAD, 16'h0020, 6'h20, 16'h0, 3'd7);
    tick;
    req(OP_STORE, 16'h0002, 6'd0, 16'h5555, 3'd1);
    tick;
    tick;
    total++;
    if ({bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 1'b0, 3'd7, 16'hA000}) begin
      bad++;
      $display("FAIL bp_resp: got v=%b we=%b f=%b rd=%0d data=%h want 1 1 0 7 a000", bus.wb_valid, bus.wb_we, bus.wb_fault, bus.wb_rd, bus.wb_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.in_ready} !== {1'b1, 3'd7, 16'hA000, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b rd=%0d data=%h rdy=%b want 1 7 a000 0", i, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.in_ready);
      end
    end
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_done: got %b want 01", {bus.wb_valid, bus.in_ready});
    end
    total++;
    if ({we_cnt - w0, re_cnt - r0, mem[2]} !== {32'd0, 32'd1, 16'hA002}) begin
      bad++;
      $display("FAIL bp_ignored: got we=%0d re=%0d mem2=%h want 0 1 a002", we_cnt - w0, re_cnt - r0, mem[2]);
    end
  endtask

  task test_fault;
    int w0, r0;
    w0 = we_cnt;
    r0 = re_cnt;
    req(OP_LOAD, 16'h003F, 6'd1, 16'h0, 3'd3);
    tick;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.wb_fault, bus.wb_we, bus.wb_rd, bus.wb_data, bus.mem_re, bus.mem_we, bus.fault_count} !== {1'b1, 1'b1, 1'b0, 3'd3, 16'h0, 1'b0, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL fault_resp: got v=%b f=%b we=%b rd=%0d data=%h re=%b mwe=%b cnt=%0d want 1 1 0 3 0000 0 0 1", bus.wb_valid, bus.wb_fault, bus.wb_we, bus.wb_rd, bus.wb_data, bus.mem_re, bus.mem_we, bus.fault_count);
    end
    bus.wb_ready = 1'b1;
    tick;
    total++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL fault_done: got %b want 01", {bus.wb_valid, bus.in_ready});
    end
    req(OP_STORE, 16'h0000, 6'h3F, 16'h7777, 3'd5);
    tick;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.wb_fault, bus.wb_we, bus.wb_rd, bus.mem_we, bus.fault_count} !== {1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 8'd2}) begin
      bad++;
      $display("FAIL fault_neg1: got v=%b f=%b we=%b rd=%0d mwe=%b cnt=%0d want 1 1 0 5 0 2", bus.wb_valid, bus.wb_fault, bus.wb_we, bus.wb_rd, bus.mem_we, bus.fault_count);
    end
    tick;
    bus.wb_ready = 1'b0;
    total++;
    if ({we_cnt - w0, re_cnt - r0, bus.in_ready} !== {32'd0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL fault_no_mem: got we=%0d re=%0d rdy=%b want 0 0 1", we_cnt - w0, re_cnt - r0, bus.in_ready);
    end
  endtask

  task test_fault_saturate;
    bus.wb_ready = 1'b1;
    req(OP_LOAD, 16'h0100, 6'd0, 16'h0, 3'd0);
    repeat (610) tick;
    bus.in_valid = 1'b0;
    repeat (2) tick;
    bus.wb_ready = 1'b0;
    total++;
    if ({bus.fault_count, bus.in_ready, bus.wb_valid} !== {8'hFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fault_saturate: got cnt=%0d rdy=%b v=%b want 255 1 0", bus.fault_count, bus.in_ready, bus.wb_valid);
    end
  endtask

  task test_reset_mid_store;
    int w0;
    w0 = we_cnt;
    req(OP_STORE, 16'h0001, 6'd0, 16'h1234, 3'd0);
    tick;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 6'd1, 16'h1234}) begin
      bad++;
      $display("FAIL rst_pre: got we=%b waddr=%0d wdata=%h want 1 1 1234", bus.mem_we, bus.mem_waddr, bus.mem_wdata);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.mem_we, bus.mem_re, bus.wb_valid, bus.in_ready, bus.fault_count} !== 12'h0) begin
      bad++;
      $display("FAIL rst_async: got we=%b re=%b v=%b rdy=%b cnt=%0d want all 0", bus.mem_we, bus.mem_re, bus.wb_valid, bus.in_ready, bus.fault_count);
    end
    repeat (2) tick;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL rst_no_resp[%0d]: got %b want 01", i, {bus.wb_valid, bus.in_ready});
      end
    end
    total++;
    if ({mem[1], we_cnt - w0} !== {16'hA001, 32'd0}) begin
      bad++;
      $display("FAIL rst_no_write: got mem1=%h writes=%0d want a001 0", mem[1], we_cnt - w0);
    end
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL mem_exclusive: got %0d overlapping cycles want 0", both_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    test_reset;
    test_store;
    test_load;
    test_backpressure;
    test_fault;
    test_fault_saturate;
    test_reset_mid_store;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Load/store unit sitting directly upstream of the data memory in the 16-bit datapath. It accepts one load or store per handshake from execute and computes the effective address as base + sign-extended offset. It drives the data memory's read/write enables, addresses and write data, then captures the registered read data. It returns a writeback response, or an address fault, to the register-file stage.

Parameters:
DATA_W, 16, datapath/word width
ADDR_W, 6, data-memory address width (64 words)
REG_W, 3, destination register index width
OFF_W, 6, signed immediate offset width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  request valid
in_ready  out  1  stage can accept request
in_op  in  1  0 = load, 1 = store
in_base  in  DATA_W  base register value
in_offset  in  OFF_W  signed offset
in_store_data  in  DATA_W  store data
in_rd  in  REG_W  load destination register
mem_re  out  1  data-memory read enable
mem_raddr  out  ADDR_W  read address
mem_we  out  1  data-memory write enable
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  data-memory read data (valid the cycle after the edge that sampled mem_re)
wb_valid  out  1  response valid
wb_ready  in  1  consumer accepts response
wb_we  out  1  register write required (loads only)
wb_rd  out  REG_W  destination register
wb_data  out  DATA_W  load data (0 for stores and faults)
wb_fault  out  1  effective address out of range
fault_count  out  8  saturating count of faulted requests

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces: state IDLE; in_ready=0 while reset is held; mem_re=mem_we=0; mem_raddr=mem_waddr=0; mem_wdata=0; wb_valid=wb_we=wb_fault=0; wb_rd=0; wb_data=0; fault_count=0.
- States: IDLE, ISSUE, CAPTURE, RESP. in_ready = (state==IDLE), derived from the state register.
- Accept on the edge where in_valid & in_ready. At that edge:
  - ea = in_base + sign_extend(in_offset), computed modulo 2^16.
  - fault = (ea[15:ADDR_W] != 0).
  - op, rd, store data and ea[ADDR_W-1:0] are latched.
- Fault path: IDLE -> RESP on the accept edge.
  - wb_fault=1, wb_we=0, wb_data=0, wb_rd=latched rd.
  - No memory enable is ever asserted.
  - fault_count increments and saturates at 255.
- Load path:
  - IDLE -> ISSUE: mem_re=1, mem_raddr=ea.
  - ISSUE -> CAPTURE: mem_re drops to 0.
  - CAPTURE -> RESP: wb_data <= mem_rdata, wb_we=1.
  - wb_valid rises after the 3rd edge following the accept edge.
- Store path:
  - IDLE -> ISSUE: mem_we=1 for exactly one cycle, with mem_waddr=ea and mem_wdata=store data.
  - ISSUE -> RESP: wb_we=0, wb_data=0.
  - wb_valid rises after the 2nd edge following the accept edge.
- RESP: wb_valid=1 and all wb_* outputs are held stable until wb_ready=1. On that edge: wb_valid=0, go to IDLE.
  - No new request is accepted in the same cycle.
- mem_re and mem_we are never high in the same cycle. Each is high for at most one cycle per request.
- Offset boundaries:
  - in_offset = -32 with in_base = 32 gives ea = 0, valid.
  - in_base = 0, offset = -1 gives ea = 0xFFFF, fault.
- in_valid while not IDLE is ignored; the requester must hold it.
- Reset mid-operation: all state and enables clear immediately, and the in-flight request is dropped with no response. A store whose ISSUE edge has not yet occurred is not written.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, RESP=2'd3.
  - Op encoding: OP_LOAD=1'b0, OP_STORE=1'b1.
  - DATA_W, ADDR_W and REG_W defaults.
- One natural sub-module: ea_calc, which is combinational and produces sign extension, the 16-bit add and the fault flag.
- The FSM and registers stay in the top.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, in_ready=1, fault_count=0.
- Store: base=0x0010, offset=+5, data=0xBEEF -> mem_we=1 for one cycle with waddr=21, wdata=0xBEEF; wb_valid 2 edges later with wb_we=0 and wb_fault=0.
- Load after that store: base=0x0018, offset=-3, rd=4 -> mem_re=1 with raddr=21; wb_valid 3 edges after accept with wb_data=0xBEEF, wb_rd=4, wb_we=1.
- Fault: base=0x003F, offset=+1 (ea=64) -> no mem_re or mem_we; wb_fault=1, wb_we=0; fault_count=1. Repeat 300 faults -> fault_count=255.
- Backpressure: wb_ready=0 for 5 cycles during a load response -> wb_data/wb_rd stable, in_ready=0, in_valid ignored. Raise wb_ready -> IDLE next edge.
- Reset asserted asynchronously during a store's ISSUE cycle -> mem_we falls immediately without waiting for a clock; the location is unchanged; no wb_valid after release.
